cluster_ce: RTL and testbench



---
 rtl/cluster_ce.sv | 157 +++++++++++++++
 tb/tb_cluster_ce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cluster_ce.sv
// Compare-exchange element for one kd-tree parent node. It orders left <= parent <= right
// on the split axis, marks the slots that moved, and registers the result in one stage.
module cluster_ce #(
   parameter int dim         = 3,
   parameter int data_range  = 255,
   parameter int dim_size    = $clog2(data_range),
   parameter int center_size = dim * dim_size,
   parameter int axis_size   = $clog2(dim)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sorting,
   input  logic                   left_en,
   input  logic                   right_en,
   input  logic [center_size-1:0] left,
   input  logic [center_size-1:0] parent,
   input  logic [center_size-1:0] right,
   input  logic [center_size-1:0] point_in,
   input  logic [axis_size-1:0]   axis,
   output logic                   stable,
   output logic                   left_switch,
   output logic                   parent_switch,
   output logic                   right_switch,
   output logic [center_size-1:0] new_left,
   output logic [center_size-1:0] new_parent,
   output logic [center_size-1:0] new_right,
   output logic [axis_size-1:0]   child_axis
);

   localparam logic [axis_size:0] dim_c = dim[axis_size:0];
   localparam logic [axis_size:0] one_c = {{axis_size{1'b0}}, 1'b1};

   function automatic logic [dim_size-1:0] key_of(input logic [center_size-1:0] c,
                                                  input logic [axis_size-1:0]   ax);
      key_of = '0;
      for (int k = 0; k < dim; k++) begin
         if (ax == k[axis_size-1:0]) key_of = c[k*dim_size +: dim_size];
      end
   endfunction

   logic                   unused_point;
   logic [dim_size-1:0]    key_l, key_p, key_r;
   logic                   gt_lp, gt_lr, gt_pr;
   logic [1:0]             rank_l, rank_p, rank_r;
   logic                   axis_valid;
   logic [axis_size:0]     axis_inc;
   logic [center_size-1:0] sel_l, sel_p, sel_r;
   logic                   sw_l, sw_p, sw_r;

   logic [center_size-1:0] new_left_d, new_left_q, new_parent_d, new_parent_q;
   logic [center_size-1:0] new_right_d, new_right_q;
   logic                   left_switch_d, left_switch_q, parent_switch_d, parent_switch_q;
   logic                   right_switch_d, right_switch_q, stable_d, stable_q;
   logic [axis_size-1:0]   child_axis_d, child_axis_q;

   assign unused_point = ^point_in;

   // Strict greater-than keeps equal keys in their original left/parent/right order.
   assign key_l      = key_of(left, axis);
   assign key_p      = key_of(parent, axis);
   assign key_r      = key_of(right, axis);
   assign gt_lp      = key_l > key_p;
   assign gt_lr      = key_l > key_r;
   assign gt_pr      = key_p > key_r;
   assign rank_l     = {1'b0, gt_lp} + {1'b0, gt_lr};
   assign rank_p     = {1'b0, ~gt_lp} + {1'b0, gt_pr};
   assign rank_r     = {1'b0, ~gt_lr} + {1'b0, ~gt_pr};
   assign axis_valid = {1'b0, axis} < dim_c;
   assign axis_inc   = {1'b0, axis} + one_c;

   always_comb begin
      sel_l = left;
      sel_p = parent;
      sel_r = right;
      sw_l  = 1'b0;
      sw_p  = 1'b0;
      sw_r  = 1'b0;
      if (sorting && axis_valid) begin
         if (left_en && right_en) begin
            sel_l = (rank_l == 2'd0) ? left : (rank_p == 2'd0) ? parent : right;
            sel_p = (rank_l == 2'd1) ? left : (rank_p == 2'd1) ? parent : right;
            sel_r = (rank_l == 2'd2) ? left : (rank_p == 2'd2) ? parent : right;
            sw_l  = rank_l != 2'd0;
            sw_p  = rank_p != 2'd1;
            sw_r  = rank_r != 2'd2;
         end else if (!left_en && right_en) begin
            if (gt_pr) begin
               sel_p = right;
               sel_r = parent;
               sw_p  = 1'b1;
               sw_r  = 1'b1;
            end
         end else if (left_en && !right_en) begin
            if (gt_lp) begin
               sel_l = parent;
               sel_p = left;
               sw_l  = 1'b1;
               sw_p  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      new_left_d      = new_left_q;
      new_parent_d    = new_parent_q;
      new_right_d     = new_right_q;
      left_switch_d   = left_switch_q;
      parent_switch_d = parent_switch_q;
      right_switch_d  = right_switch_q;
      stable_d        = stable_q;
      child_axis_d    = child_axis_q;
      if (en) begin
         new_left_d      = sel_l;
         new_parent_d    = sel_p;
         new_right_d     = sel_r;
         left_switch_d   = sw_l;
         parent_switch_d = sw_p;
         right_switch_d  = sw_r;
         stable_d        = ~(sw_l | sw_p | sw_r);
         child_axis_d    = (axis_inc >= dim_c) ? '0 : axis_inc[axis_size-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         new_left_q      <= '0;
         new_parent_q    <= '0;
         new_right_q     <= '0;
         left_switch_q   <= 1'b0;
         parent_switch_q <= 1'b0;
         right_switch_q  <= 1'b0;
         stable_q        <= 1'b0;
         child_axis_q    <= '0;
      end else begin
         new_left_q      <= new_left_d;
         new_parent_q    <= new_parent_d;
         new_right_q     <= new_right_d;
         left_switch_q   <= left_switch_d;
         parent_switch_q <= parent_switch_d;
         right_switch_q  <= right_switch_d;
         stable_q        <= stable_d;
         child_axis_q    <= child_axis_d;
      end
   end

   assign new_left      = new_left_q;
   assign new_parent    = new_parent_q;
   assign new_right     = new_right_q;
   assign left_switch   = left_switch_q;
   assign parent_switch = parent_switch_q;
   assign right_switch  = right_switch_q;
   assign stable        = stable_q;
   assign child_axis    = child_axis_q;

endmodule

// File: tb/tb_cluster_ce.sv
// Bench for cluster_ce: directed steps from the node-ordering rules, then random traffic,
// all checked against a stable-sort reference of the enabled slots.
module tb_cluster_ce;

   localparam int DIM = 3;
   localparam int DS  = 8;
   localparam int CS  = DIM * DS;
   localparam int AS  = 2;

   logic          clk = 1'b0;
   logic          rst, en, sorting, left_en, right_en;
   logic [CS-1:0] left, parent, right, point_in;
   logic [AS-1:0] axis;
   logic          stable, left_switch, parent_switch, right_switch;
   logic [CS-1:0] new_left, new_parent, new_right;
   logic [AS-1:0] child_axis;

   int total = 0;
   int bad   = 0;

   logic [CS-1:0] m_new[3];
   logic          m_sw[3];
   logic          m_stable;
   logic [AS-1:0] m_cax;

   cluster_ce dut (
      .clk(clk), .rst(rst), .en(en), .sorting(sorting),
      .left_en(left_en), .right_en(right_en),
      .left(left), .parent(parent), .right(right), .point_in(point_in), .axis(axis),
      .stable(stable), .left_switch(left_switch), .parent_switch(parent_switch),
      .right_switch(right_switch), .new_left(new_left), .new_parent(new_parent),
      .new_right(new_right), .child_axis(child_axis)
   );

   always #5 clk = ~clk;

   function automatic logic [CS-1:0] pack(input int c0, input int c1, input int c2);
      logic [CS-1:0] v;
      v = '0;
      v[0 +: DS]    = c0[DS-1:0];
      v[DS +: DS]   = c1[DS-1:0];
      v[2*DS +: DS] = c2[DS-1:0];
      return v;
   endfunction

   function automatic int key_of(input logic [CS-1:0] c, input int a);
      return int'(c[a*DS +: DS]);
   endfunction

   // Reference: bubble-sort the enabled window of slots by key; strict compare keeps ties.
   task automatic model_edge();
      logic [CS-1:0] c[3];
      int ord[3];
      int lo, hi, t, ax, nx;
      if (rst) begin
         for (int s = 0; s < 3; s++) begin
            m_new[s] = '0;
            m_sw[s]  = 1'b0;
         end
         m_stable = 1'b0;
         m_cax    = '0;
      end else if (en) begin
         c[0] = left; c[1] = parent; c[2] = right;
         ord[0] = 0; ord[1] = 1; ord[2] = 2;
         ax = int'(axis);
         if (sorting && ax < DIM) begin
            lo = left_en ? 0 : 1;
            hi = right_en ? 2 : 1;
            for (int pass = 0; pass < 2; pass++)
               for (int j = lo; j < hi; j++)
                  if (key_of(c[ord[j]], ax) > key_of(c[ord[j+1]], ax)) begin
                     t = ord[j]; ord[j] = ord[j+1]; ord[j+1] = t;
                  end
         end
         for (int s = 0; s < 3; s++) begin
            m_new[s] = c[ord[s]];
            m_sw[s]  = (ord[s] != s);
         end
         m_stable = !(m_sw[0] || m_sw[1] || m_sw[2]);
         nx = ax + 1;
         if (nx >= DIM) nx = 0;
         m_cax = nx[AS-1:0];
      end
   endtask

   task automatic chk(input string tag, input logic [CS-1:0] obs, input logic [CS-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      chk({step, ".new_left"},   new_left,   m_new[0]);
      chk({step, ".new_parent"}, new_parent, m_new[1]);
      chk({step, ".new_right"},  new_right,  m_new[2]);
      chk({step, ".left_switch"},   {{(CS-1){1'b0}}, left_switch},   {{(CS-1){1'b0}}, m_sw[0]});
      chk({step, ".parent_switch"}, {{(CS-1){1'b0}}, parent_switch}, {{(CS-1){1'b0}}, m_sw[1]});
      chk({step, ".right_switch"},  {{(CS-1){1'b0}}, right_switch},  {{(CS-1){1'b0}}, m_sw[2]});
      chk({step, ".stable"},     {{(CS-1){1'b0}}, stable},     {{(CS-1){1'b0}}, m_stable});
      chk({step, ".child_axis"}, {{(CS-AS){1'b0}}, child_axis}, {{(CS-AS){1'b0}}, m_cax});
   endtask

   task automatic set_in(input logic e, input logic s, input logic le, input logic re,
                         input logic [CS-1:0] l, input logic [CS-1:0] p,
                         input logic [CS-1:0] r, input int ax);
      en       = e;
      sorting  = s;
      left_en  = le;
      right_en = re;
      left     = l;
      parent   = p;
      right    = r;
      axis     = ax[AS-1:0];
      point_in = CS'($urandom);
   endtask

   task automatic cyc(input string step);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(step);
   endtask

   function automatic int rnd_coord();
      return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
   endfunction

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, '0, '0, '0, 0);
      @(negedge clk);
      cyc("reset");
      chk("reset.stable_zero", {{(CS-1){1'b0}}, stable}, '0);
      rst = 1'b0;

      set_in(1, 1, 1, 1, pack(101, 0, 0), pack(102, 0, 0), pack(103, 0, 0), 0);
      cyc("ordered");
      set_in(1, 1, 1, 1, pack(255, 0, 0), pack(254, 0, 0), pack(253, 0, 0), 0);
      cyc("reversal");
      chk("reversal.lit_new_left", new_left, pack(253, 0, 0));
      set_in(1, 1, 1, 1, pack(32, 0, 0), pack(167, 0, 0), pack(17, 0, 0), 0);
      cyc("rotation");
      set_in(1, 1, 1, 1, pack(32, 0, 0), pack(167, 0, 0), pack(17, 0, 0), 2);
      cyc("axis2_zero_keys");
      set_in(1, 1, 0, 1, pack(50, 0, 0), pack(150, 0, 0), pack(60, 0, 0), 0);
      cyc("left_dis");
      set_in(1, 1, 1, 0, pack(199, 0, 0), pack(201, 0, 0), pack(42, 0, 0), 0);
      cyc("right_dis");
      set_in(1, 1, 1, 0, pack(9, 200, 0), pack(9, 100, 0), pack(9, 50, 0), 1);
      cyc("right_dis_swap");
      set_in(1, 0, 1, 1, pack(32, 0, 0), pack(167, 0, 0), pack(17, 0, 0), 0);
      cyc("pass_sorting0");
      set_in(1, 1, 0, 0, pack(32, 0, 0), pack(167, 0, 0), pack(17, 0, 0), 0);
      cyc("pass_no_children");
      set_in(1, 1, 1, 1, pack(32, 0, 9), pack(167, 0, 5), pack(17, 0, 1), 3);
      cyc("axis3_pass");
      set_in(1, 1, 1, 1, pack(5, 1, 0), pack(5, 2, 0), pack(5, 3, 0), 0);
      cyc("ties");
      set_in(1, 1, 1, 1, pack(7, 30, 1), pack(7, 10, 2), pack(7, 20, 3), 1);
      cyc("axis1_sort");

      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, 1, 1, pack(rnd_coord(), rnd_coord(), rnd_coord()),
                pack(rnd_coord(), rnd_coord(), rnd_coord()),
                pack(rnd_coord(), rnd_coord(), rnd_coord()), int'($urandom_range(0, 3)));
         cyc("en_low_hold");
      end

      set_in(1, 1, 1, 1, pack(255, 0, 0), pack(254, 0, 0), pack(253, 0, 0), 0);
      rst = 1'b1;
      cyc("mid_reset");
      rst = 1'b0;
      en  = 1'b0;
      cyc("after_reset_en0");

      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                pack(rnd_coord(), rnd_coord(), rnd_coord()),
                pack(rnd_coord(), rnd_coord(), rnd_coord()),
                pack(rnd_coord(), rnd_coord(), rnd_coord()), int'($urandom_range(0, 3)));
         rst = ($urandom_range(0, 39) == 0);
         cyc("random");
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
